mips_divider: RTL and testbench

- Iterative multi-cycle integer divider for the MIPS execute stage. It is the inverse-operation counterpart to the single-cycle combinational ALU multiply path.
- Implements DIV and DIVU. Produces quotient (LO) and remainder (HI) using radix-2 restoring division over a start/busy/done handshake.
- The pipeline control stalls on div_busy and captures results on div_done.

---
 rtl/mips_divider.sv | 112 +++++++++++
 tb/tb_mips_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_divider.sv
// Radix-2 restoring divider for DIV/DIVU: WIDTH restoring steps, then a sign fix-up,
// with a start/busy/done handshake toward the pipeline.
//   state | meaning
//   IDLE  | waiting for div_start; latches operands on acceptance
//   RUN   | one restoring step per clock, WIDTH steps
//   FIX   | sign correction and result write, raises div_done
//   DONE  | div_done cycle, returns to IDLE
module mips_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_dividend,
   input  logic [WIDTH-1:0] div_divisor,
   output logic             div_busy,
   output logic             div_done,
   output logic [WIDTH-1:0] div_quotient,
   output logic [WIDTH-1:0] div_remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dvs, raw_dvd;
   logic             q_neg, r_neg, dz;

   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_abs, dvs_abs, q_fix, r_fix;
   logic [WIDTH:0]   shifted, diff;

   always_comb begin
      dvd_neg = div_signed & div_dividend[WIDTH-1];
      dvs_neg = div_signed & div_divisor[WIDTH-1];
      dvd_abs = dvd_neg ? -div_dividend : div_dividend;
      dvs_abs = dvs_neg ? -div_divisor : div_divisor;
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      // divide by zero bypasses sign correction and reports the raw dividend
      q_fix   = dz ? '1 : (q_neg ? -quo : quo);
      r_fix   = dz ? raw_dvd : (r_neg ? -rem : rem);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (div_start) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign div_busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         rem           <= '0;
         quo           <= '0;
         dvs           <= '0;
         raw_dvd       <= '0;
         q_neg         <= 1'b0;
         r_neg         <= 1'b0;
         dz            <= 1'b0;
         div_done      <= 1'b0;
         div_quotient  <= '0;
         div_remainder <= '0;
         div_by_zero   <= 1'b0;
      end else begin
         state    <= state_nxt;
         div_done <= (state == FIX);
         case (state)
            IDLE: begin
               if (div_start) begin
                  raw_dvd <= div_dividend;
                  quo     <= dvd_abs;
                  dvs     <= dvs_abs;
                  rem     <= '0;
                  cnt     <= '0;
                  q_neg   <= dvd_neg ^ dvs_neg;
                  r_neg   <= dvd_neg;
                  dz      <= (div_divisor == '0);
               end
            end
            RUN: begin
               if (!diff[WIDTH]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               div_quotient  <= q_fix;
               div_remainder <= r_fix;
               div_by_zero   <= dz;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_divider.sv
// Scoreboard bench for mips_divider: expected results queued at issue, popped on div_done.
module tb_mips_divider;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         div_start = 1'b0;
   logic         div_signed = 1'b0;
   logic [W-1:0] div_dividend = '0;
   logic [W-1:0] div_divisor = '0;
   logic         div_busy, div_done, div_by_zero;
   logic [W-1:0] div_quotient, div_remainder;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   mips_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_busy(div_busy), .div_done(div_done), .div_quotient(div_quotient),
      .div_remainder(div_remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa, sd, qq, rr;
      if (b == '0) begin
         e.q = '1; e.r = a; e.dz = 1'b1;
      end else if (s) begin
         sa = longint'($signed(a));
         sd = longint'($signed(b));
         qq = sa / sd;
         rr = sa % sd;
         e.q = qq[W-1:0]; e.r = rr[W-1:0]; e.dz = 1'b0;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (div_done) begin
         done_cnt++;
         check("sb_has_entry", W'(sb.size() != 0), W'(1));
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("quotient", div_quotient, mon_e.q);
            check("remainder", div_remainder, mon_e.r);
            check("by_zero", W'(div_by_zero), W'(mon_e.dz));
         end
      end
   end

   task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit push, output int e0);
      @(negedge clk);
      div_start = 1'b1; div_signed = s; div_dividend = a; div_divisor = b;
      e0 = cyc + 1;
      if (push) sb.push_back(model(s, a, b));
      @(posedge clk);
      #1;
      div_start = 1'b0;
      div_dividend = $urandom;
      div_divisor = $urandom;
      div_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_n);
      int e0;
      start_op(s, a, b, 1'b1, e0);
      lat = -1;
      busy_n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (div_done) lat = cyc - e0;
         if (div_busy) busy_n++;
         else break;
      end
   endtask

   logic         dir_s[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [W-1:0] dir_a[8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678, 32'd10,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF9C};
   logic [W-1:0] dir_b[8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd3,
                             32'hFFFF_FFFF, 32'd1, 32'd0};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, busy_n, e0, d0, k, dc, hit;
      int t[2];

      #1;
      check("rst_busy", W'(div_busy), '0);
      check("rst_done", W'(div_done), '0);
      check("rst_quotient", div_quotient, '0);
      check("rst_remainder", div_remainder, '0);
      check("rst_by_zero", W'(div_by_zero), '0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         logic         s;
         logic [W-1:0] a, b;
         if (i < 8) begin
            s = dir_s[i]; a = dir_a[i]; b = dir_b[i];
         end else begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
         end
         run_op(s, a, b, lat, busy_n);
         check("latency", W'(lat), W'(33));
         check("busy_cycles", W'(busy_n), W'(34));
      end

      // starts during RUN and during the done cycle must be ignored
      d0 = done_cnt;
      start_op(1'b0, 32'd50, 32'd5, 1'b1, e0);
      repeat (10) @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; div_dividend = 32'd9; div_divisor = 32'd4;
      @(posedge clk);
      #1 div_start = 1'b0;
      hit = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_done) begin hit = 1; break; end
      end
      check("hs_done_seen", W'(hit), W'(1));
      div_start = 1'b1; div_dividend = 32'd9; div_divisor = 32'd4;
      @(posedge clk);
      #1 div_start = 1'b0;
      repeat (40) @(negedge clk);
      check("hs_done_pulses", W'(done_cnt - d0), W'(1));
      check("hs_idle", W'(div_busy), '0);

      // start held high: back-to-back ops, done pulses 35 cycles apart
      sb.push_back(model(1'b0, 32'd1000, 32'd7));
      sb.push_back(model(1'b0, 32'd1000, 32'd7));
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; div_dividend = 32'd1000; div_divisor = 32'd7;
      e0 = cyc + 1;
      k = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (div_done) begin
            t[k] = cyc;
            k++;
            if (k == 2) begin div_start = 1'b0; break; end
         end
      end
      div_start = 1'b0;
      check("held_done_count", W'(k), W'(2));
      if (k == 2) begin
         check("held_first_latency", W'(t[0] - e0), W'(33));
         check("held_spacing", W'(t[1] - t[0]), W'(35));
      end
      repeat (3) @(negedge clk);

      // asynchronous reset in the middle of a run
      start_op(1'b0, 32'd77, 32'd3, 1'b1, e0);
      repeat (15) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      sb.delete();
      #1;
      check("mid_rst_busy", W'(div_busy), '0);
      check("mid_rst_done", W'(div_done), '0);
      check("mid_rst_quotient", div_quotient, '0);
      check("mid_rst_remainder", div_remainder, '0);
      check("mid_rst_by_zero", W'(div_by_zero), '0);
      @(negedge clk);
      rst = 1'b0;
      dc = done_cnt;
      repeat (50) @(negedge clk);
      check("mid_rst_no_done", W'(done_cnt - dc), '0);
      run_op(1'b0, 32'd10, 32'd3, lat, busy_n);
      check("post_rst_latency", W'(lat), W'(33));

      repeat (5) @(negedge clk);
      check("sb_drained", W'(sb.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
